// File: rtl/vga_timing_engine_if.sv
// Signal bundle between the VGA timing engine, its frame-buffer reader and the board DAC.
// Cursor-overlay signals exist only when VGA_CURSOR_EN is defined.
interface vga_timing_engine_if #(
  parameter int COLOR_W = 8,
  parameter int ADDR_W  = 20
);
  logic [COLOR_W-1:0] iRed;
  logic [COLOR_W-1:0] iGreen;
  logic [COLOR_W-1:0] iBlue;
  logic               oReq;
  logic [11:0]        oCoord_X;
  logic [11:0]        oCoord_Y;
  logic [ADDR_W-1:0]  oAddress;
  logic               oLine_Start;
  logic               oFrame_Start;
  logic [COLOR_W-1:0] oVGA_R;
  logic [COLOR_W-1:0] oVGA_G;
  logic [COLOR_W-1:0] oVGA_B;
  logic               oVGA_H_SYNC;
  logic               oVGA_V_SYNC;
  logic               oVGA_BLANK_N;
  logic               oVGA_SYNC;
  logic               oVGA_CLOCK;

`ifdef VGA_CURSOR_EN
  logic               iCursor_EN;
  logic [11:0]        iCursor_X;
  logic [11:0]        iCursor_Y;
  logic [COLOR_W-1:0] iCursor_R;
  logic [COLOR_W-1:0] iCursor_G;
  logic [COLOR_W-1:0] iCursor_B;

  modport master (
    input  iRed, iGreen, iBlue,
    input  iCursor_EN, iCursor_X, iCursor_Y, iCursor_R, iCursor_G, iCursor_B,
    output oReq, oCoord_X, oCoord_Y, oAddress, oLine_Start, oFrame_Start,
    output oVGA_R, oVGA_G, oVGA_B, oVGA_H_SYNC, oVGA_V_SYNC,
    output oVGA_BLANK_N, oVGA_SYNC, oVGA_CLOCK
  );

  modport slave (
    output iRed, iGreen, iBlue,
    output iCursor_EN, iCursor_X, iCursor_Y, iCursor_R, iCursor_G, iCursor_B,
    input  oReq, oCoord_X, oCoord_Y, oAddress, oLine_Start, oFrame_Start,
    input  oVGA_R, oVGA_G, oVGA_B, oVGA_H_SYNC, oVGA_V_SYNC,
    input  oVGA_BLANK_N, oVGA_SYNC, oVGA_CLOCK
  );
`else
  modport master (
    input  iRed, iGreen, iBlue,
    output oReq, oCoord_X, oCoord_Y, oAddress, oLine_Start, oFrame_Start,
    output oVGA_R, oVGA_G, oVGA_B, oVGA_H_SYNC, oVGA_V_SYNC,
    output oVGA_BLANK_N, oVGA_SYNC, oVGA_CLOCK
  );

  modport slave (
    output iRed, iGreen, iBlue,
    input  oReq, oCoord_X, oCoord_Y, oAddress, oLine_Start, oFrame_Start,
    input  oVGA_R, oVGA_G, oVGA_B, oVGA_H_SYNC, oVGA_V_SYNC,
    input  oVGA_BLANK_N, oVGA_SYNC, oVGA_CLOCK
  );
`endif
endinterface

// File: rtl/vga_timing_engine.sv
// Programmable VGA raster controller: sync/blank/RGB to the DAC plus a pixel-fetch stream leading
// display by FETCH_LAT cycles. Define VGA_CURSOR_EN to add the cursor-box colour overlay.
module vga_timing_engine #(
  parameter int H_ACT     = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACT     = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit SYNC_POL  = 1'b0,
  parameter int FETCH_LAT = 2,
  parameter int COLOR_W   = 8,
  parameter int ADDR_W    = 20
`ifdef VGA_CURSOR_EN
  ,
  parameter int CUR_RAD   = 1
`endif
) (
  input logic                 iCLK,
  input logic                 iRST_N,
  vga_timing_engine_if.master vga
);

  localparam int H_TOT     = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT     = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int H_ACT_BEG = H_SYNC + H_BP;
  localparam int H_ACT_END = H_ACT_BEG + H_ACT;
  // Requests run FETCH_LAT cycles ahead of display; H_BP >= FETCH_LAT keeps them inside the line.
  localparam int H_REQ_BEG = H_ACT_BEG - FETCH_LAT;
  localparam int H_REQ_END = H_REQ_BEG + H_ACT;
  localparam int V_ACT_BEG = V_SYNC + V_BP;
  localparam int V_ACT_END = V_ACT_BEG + V_ACT;

  logic [11:0] h_q, h_d;
  logic [11:0] v_q, v_d;

  always_comb begin
    h_d = h_q + 12'd1;
    v_d = v_q;
    if (h_q == 12'(H_TOT - 1)) begin
      h_d = '0;
      v_d = (v_q == 12'(V_TOT - 1)) ? 12'd0 : v_q + 12'd1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  logic              h_act, v_act, h_req;
  logic              pix_on, req_on;
  logic              hs_on, vs_on;
  logic [11:0]       req_x, req_y;
  logic [ADDR_W-1:0] req_addr;

  always_comb begin
    h_act    = (h_q >= 12'(H_ACT_BEG)) && (h_q < 12'(H_ACT_END));
    v_act    = (v_q >= 12'(V_ACT_BEG)) && (v_q < 12'(V_ACT_END));
    h_req    = (h_q >= 12'(H_REQ_BEG)) && (h_q < 12'(H_REQ_END));
    pix_on   = h_act && v_act;
    req_on   = h_req && v_act;
    hs_on    = (h_q < 12'(H_SYNC));
    vs_on    = (v_q < 12'(V_SYNC));
    req_x    = h_q - 12'(H_REQ_BEG);
    req_y    = v_q - 12'(V_ACT_BEG);
    req_addr = ADDR_W'(32'(req_y) * 32'(H_ACT) + 32'(req_x));
  end

`ifdef VGA_CURSOR_EN
  // Signed distance so a cursor near the origin never wraps onto the far edges.
  function automatic logic cur_near(input logic [11:0] a, input logic [11:0] c);
    logic signed [13:0] d;
    d = $signed({2'b00, a}) - $signed({2'b00, c});
    if (d < 0) d = -d;
    return ($unsigned(d) <= 14'(CUR_RAD));
  endfunction

  logic [11:0] pix_x, pix_y;
  logic        cur_hit;

  always_comb begin
    pix_x   = h_q - 12'(H_ACT_BEG);
    pix_y   = v_q - 12'(V_ACT_BEG);
    cur_hit = vga.iCursor_EN && cur_near(pix_x, vga.iCursor_X) && cur_near(pix_y, vga.iCursor_Y);
  end
`endif

  logic [COLOR_W-1:0] r_d, g_d, b_d;

  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (pix_on) begin
`ifdef VGA_CURSOR_EN
      if (cur_hit) begin
        r_d = vga.iCursor_R;
        g_d = vga.iCursor_G;
        b_d = vga.iCursor_B;
      end else begin
        r_d = vga.iRed;
        g_d = vga.iGreen;
        b_d = vga.iBlue;
      end
`else
      r_d = vga.iRed;
      g_d = vga.iGreen;
      b_d = vga.iBlue;
`endif
    end
  end

  logic              hs_q, vs_q, blank_q;
  logic              req_q, ls_q, fs_q;
  logic [11:0]       x_q, y_q;
  logic [ADDR_W-1:0] addr_q;
  logic [COLOR_W-1:0] r_q, g_q, b_q;

  // Every DAC-side and fetch output is registered from the same counter state.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
      blank_q <= 1'b0;
      req_q   <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      hs_q    <= hs_on ? SYNC_POL : ~SYNC_POL;
      vs_q    <= vs_on ? SYNC_POL : ~SYNC_POL;
      blank_q <= pix_on;
      req_q   <= req_on;
      ls_q    <= (h_q == 12'd0);
      fs_q    <= (h_q == 12'd0) && (v_q == 12'd0);
      if (req_on) begin
        x_q    <= req_x;
        y_q    <= req_y;
        addr_q <= req_addr;
      end
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
    end
  end

  assign vga.oReq         = req_q;
  assign vga.oCoord_X     = x_q;
  assign vga.oCoord_Y     = y_q;
  assign vga.oAddress     = addr_q;
  assign vga.oLine_Start  = ls_q;
  assign vga.oFrame_Start = fs_q;
  assign vga.oVGA_R       = r_q;
  assign vga.oVGA_G       = g_q;
  assign vga.oVGA_B       = b_q;
  assign vga.oVGA_H_SYNC  = hs_q;
  assign vga.oVGA_V_SYNC  = vs_q;
  assign vga.oVGA_BLANK_N = blank_q;
  assign vga.oVGA_SYNC    = 1'b0;
  assign vga.oVGA_CLOCK   = iCLK;

endmodule

// File: tb/tb_vga_timing_engine.sv
// Bench for vga_timing_engine: a default-timing instance and a tiny-timing instance share clock and reset.
// The frame-buffer source is modelled as a FETCH_LAT-1 deep delay line of request addresses.
`timescale 1ns/1ps
module tb_vga_timing_engine;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vga_timing_engine_if #(.COLOR_W(8), .ADDR_W(20)) bd ();
  vga_timing_engine_if #(.COLOR_W(8), .ADDR_W(20)) bs ();

  vga_timing_engine u_def (.iCLK(clk), .iRST_N(rst_n), .vga(bd));
  vga_timing_engine #(
    .H_ACT(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
    .V_ACT(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b1), .FETCH_LAT(4)
  ) u_sml (.iCLK(clk), .iRST_N(rst_n), .vga(bs));

`ifdef VGA_CURSOR_EN
  vga_timing_engine_if #(.COLOR_W(8), .ADDR_W(20)) bc ();
  vga_timing_engine #(
    .H_ACT(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
    .V_ACT(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b1), .FETCH_LAT(4), .CUR_RAD(1)
  ) u_cur (.iCLK(clk), .iRST_N(rst_n), .vga(bc));
`endif

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", nm, act, act, exp, exp);
  endtask

  function automatic logic [23:0] f(input int a);
    logic [31:0] u;
    u = a;
    return {u[7:0], u[15:8] ^ 8'h5A, u[7:0] + u[15:8] + 8'h11};
  endfunction

  // Request history: index k holds the request seen k cycles ago.
  logic dv [0:3];
  int   da [0:3];
  logic sv [0:3];
  int   sa [0:3];

  task automatic drive_src();
    for (int k = 3; k > 0; k--) begin
      dv[k] = dv[k-1]; da[k] = da[k-1];
      sv[k] = sv[k-1]; sa[k] = sa[k-1];
    end
    dv[0] = bd.oReq; da[0] = int'(bd.oAddress);
    sv[0] = bs.oReq; sa[0] = int'(bs.oAddress);
    {bd.iRed, bd.iGreen, bd.iBlue} = dv[1] ? f(da[1]) : 24'hFFFFFF;
    {bs.iRed, bs.iGreen, bs.iBlue} = sv[3] ? f(sa[3]) : 24'hFFFFFF;
`ifdef VGA_CURSOR_EN
    {bc.iRed, bc.iGreen, bc.iBlue} = sv[3] ? f(sa[3]) : 24'hFFFFFF;
`endif
  endtask

  typedef struct {
    int n, hs, vs, bl, rq, ls, fs, x, y, a, pix;
  } vec_t;

  localparam int NT   = 17;
  localparam int NEND = 36 * 800 + 160;
  vec_t tbl [NT];

`ifdef VGA_CURSOR_EN
  localparam int NC = 9;
  int cn   [NC];
  int cexp [NC];
`endif

  initial begin
    int ti, hs_lo, bl_pre, bl35, first_req, first_bl, s_req, s_aerr, s_hs, blank_err;
    logic [23:0] rgb_s, rgb_d;

    //          n    hs vs bl rq ls fs  x  y   a  pix
    tbl[0]  = '{0,   1, 1, 0, 0, 1, 1, 0, 0,  0, -1};
    tbl[1]  = '{1,   1, 1, 0, 0, 0, 0, 0, 0,  0, -1};
    tbl[2]  = '{2,   0, 1, 0, 0, 0, 0, 0, 0,  0, -1};
    tbl[3]  = '{16,  1, 0, 0, 0, 1, 0, 0, 0,  0, -1};
    tbl[4]  = '{34,  0, 0, 0, 1, 0, 0, 0, 0,  0, -1};
    tbl[5]  = '{35,  0, 0, 0, 1, 0, 0, 1, 0,  1, -1};
    tbl[6]  = '{38,  0, 0, 1, 1, 0, 0, 4, 0,  4,  0};
    tbl[7]  = '{41,  0, 0, 1, 1, 0, 0, 7, 0,  7,  3};
    tbl[8]  = '{42,  0, 0, 1, 0, 0, 0, 7, 0,  7,  4};
    tbl[9]  = '{45,  0, 0, 1, 0, 0, 0, 7, 0,  7,  7};
    tbl[10] = '{46,  0, 0, 0, 0, 0, 0, 7, 0,  7, -1};
    tbl[11] = '{50,  0, 0, 0, 1, 0, 0, 0, 1,  8, -1};
    tbl[12] = '{89,  0, 0, 1, 1, 0, 0, 7, 3, 31, 27};
    tbl[13] = '{93,  0, 0, 1, 0, 0, 0, 7, 3, 31, 31};
    tbl[14] = '{96,  1, 0, 0, 0, 1, 0, 7, 3, 31, -1};
    tbl[15] = '{111, 0, 0, 0, 0, 0, 0, 7, 3, 31, -1};
    tbl[16] = '{112, 1, 1, 0, 0, 1, 1, 7, 3, 31, -1};

`ifdef VGA_CURSOR_EN
    cn[0] = 38; cexp[0] = 32'hFF0000;
    cn[1] = 39; cexp[1] = 32'hFF0000;
    cn[2] = 40; cexp[2] = 32'(f(2));
    cn[3] = 45; cexp[3] = 32'(f(7));
    cn[4] = 54; cexp[4] = 32'hFF0000;
    cn[5] = 55; cexp[5] = 32'hFF0000;
    cn[6] = 56; cexp[6] = 32'(f(10));
    cn[7] = 86; cexp[7] = 32'(f(24));
    cn[8] = 93; cexp[8] = 32'(f(31));
    bd.iCursor_EN = 1'b0; bd.iCursor_X = '0; bd.iCursor_Y = '0;
    bd.iCursor_R = '0; bd.iCursor_G = '0; bd.iCursor_B = '0;
    bs.iCursor_EN = 1'b0; bs.iCursor_X = '0; bs.iCursor_Y = '0;
    bs.iCursor_R = '0; bs.iCursor_G = '0; bs.iCursor_B = '0;
    bc.iCursor_EN = 1'b1; bc.iCursor_X = '0; bc.iCursor_Y = '0;
    bc.iCursor_R = 8'hFF; bc.iCursor_G = 8'h00; bc.iCursor_B = 8'h00;
    {bc.iRed, bc.iGreen, bc.iBlue} = '0;
`endif

    for (int k = 0; k < 4; k++) begin
      dv[k] = 1'b0; da[k] = 0; sv[k] = 1'b0; sa[k] = 0;
    end
    {bd.iRed, bd.iGreen, bd.iBlue} = '0;
    {bs.iRed, bs.iGreen, bs.iBlue} = '0;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      drive_src();
    end

    // Mid-line asynchronous reset: outputs must clear before the next clock edge.
    chk("pre_reset_blank_n", 32'(bs.oVGA_BLANK_N), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_sml_hsync", 32'(bs.oVGA_H_SYNC), 0);
    chk("rst_sml_vsync", 32'(bs.oVGA_V_SYNC), 0);
    chk("rst_def_hsync", 32'(bd.oVGA_H_SYNC), 1);
    chk("rst_def_vsync", 32'(bd.oVGA_V_SYNC), 1);
    chk("rst_blank_n", 32'(bs.oVGA_BLANK_N), 0);
    chk("rst_req", 32'(bs.oReq), 0);
    chk("rst_x", 32'(bs.oCoord_X), 0);
    chk("rst_y", 32'(bs.oCoord_Y), 0);
    chk("rst_addr", 32'(bs.oAddress), 0);
    chk("rst_rgb", 32'({bs.oVGA_R, bs.oVGA_G, bs.oVGA_B}), 0);
    chk("rst_pulses", 32'({bs.oLine_Start, bs.oFrame_Start}), 0);
    @(negedge clk);
    chk("rst_held_hsync", 32'(bs.oVGA_H_SYNC), 0);
    drive_src();
    rst_n = 1'b1;

    ti = 0; hs_lo = 0; bl_pre = 0; bl35 = 0; first_req = -1; first_bl = -1;
    s_req = 0; s_aerr = 0; s_hs = 0; blank_err = 0;
    for (int n = 0; n <= NEND; n++) begin
      @(negedge clk);
      rgb_s = {bs.oVGA_R, bs.oVGA_G, bs.oVGA_B};
      rgb_d = {bd.oVGA_R, bd.oVGA_G, bd.oVGA_B};

      if (ti < NT && tbl[ti].n == n) begin
        chk($sformatf("sml_hsync@%0d", n), 32'(bs.oVGA_H_SYNC), tbl[ti].hs);
        chk($sformatf("sml_vsync@%0d", n), 32'(bs.oVGA_V_SYNC), tbl[ti].vs);
        chk($sformatf("sml_blank_n@%0d", n), 32'(bs.oVGA_BLANK_N), tbl[ti].bl);
        chk($sformatf("sml_req@%0d", n), 32'(bs.oReq), tbl[ti].rq);
        chk($sformatf("sml_line_start@%0d", n), 32'(bs.oLine_Start), tbl[ti].ls);
        chk($sformatf("sml_frame_start@%0d", n), 32'(bs.oFrame_Start), tbl[ti].fs);
        chk($sformatf("sml_x@%0d", n), 32'(bs.oCoord_X), tbl[ti].x);
        chk($sformatf("sml_y@%0d", n), 32'(bs.oCoord_Y), tbl[ti].y);
        chk($sformatf("sml_addr@%0d", n), 32'(bs.oAddress), tbl[ti].a);
        chk($sformatf("sml_rgb@%0d", n), 32'(rgb_s),
            (tbl[ti].pix < 0) ? 32'd0 : 32'(f(tbl[ti].pix)));
        ti++;
      end

`ifdef VGA_CURSOR_EN
      for (int c = 0; c < NC; c++)
        if (cn[c] == n)
          chk($sformatf("cursor_rgb@%0d", n), 32'({bc.oVGA_R, bc.oVGA_G, bc.oVGA_B}), cexp[c]);
`endif

      if (n < 112) begin
        if (bs.oReq) begin
          if (int'(bs.oAddress) != s_req) s_aerr++;
          s_req++;
        end
        if (n < 16 && bs.oVGA_H_SYNC) s_hs++;
      end
      if (n == 111) begin
        chk("sml_req_per_frame", s_req, 32);
        chk("sml_addr_sequence_errs", s_aerr, 0);
        chk("sml_hsync_high_cycles", s_hs, 2);
      end

      if (!bs.oVGA_BLANK_N && rgb_s != 24'd0) blank_err++;
      if (!bd.oVGA_BLANK_N && rgb_d != 24'd0) blank_err++;

      if (n < 800 && !bd.oVGA_H_SYNC) hs_lo++;
      if (n < 28000 && bd.oVGA_BLANK_N) bl_pre++;
      if (n >= 28000 && n < 28800 && bd.oVGA_BLANK_N) bl35++;
      if (bd.oReq && first_req < 0) first_req = n;
      if (bd.oVGA_BLANK_N && first_bl < 0) first_bl = n;

      if (n == 0) begin
        chk("def_vsync_line0", 32'(bd.oVGA_V_SYNC), 0);
        chk("def_frame_start", 32'(bd.oFrame_Start), 1);
        chk("def_vga_sync", 32'(bd.oVGA_SYNC), 0);
      end
      if (n == 799)  chk("def_hsync_low_cycles", hs_lo, 96);
      if (n == 1599) chk("def_vsync_line1", 32'(bd.oVGA_V_SYNC), 0);
      if (n == 1600) chk("def_vsync_line2", 32'(bd.oVGA_V_SYNC), 1);
      if (n == 27999) chk("def_blank_lines_0_34", bl_pre, 0);
      if (n == 28144) chk("def_pixel0_rgb", 32'(rgb_d), 32'(f(0)));
      if (n == 28783) begin
        chk("def_last_px_line35_rgb", 32'(rgb_d), 32'(f(639)));
        chk("def_addr_hold", 32'(bd.oAddress), 639);
      end
      if (n == 28784) chk("def_fp_blank_n", 32'(bd.oVGA_BLANK_N), 0);
      if (n == 28799) begin
        chk("def_first_req_cycle", first_req, 28142);
        chk("def_first_blank_cycle", first_bl, 28144);
        chk("def_active_cycles_line35", bl35, 640);
      end
      if (n == 28942) begin
        chk("def_line36_req", 32'(bd.oReq), 1);
        chk("def_line36_addr", 32'(bd.oAddress), 640);
        chk("def_line36_y", 32'(bd.oCoord_Y), 1);
      end

      drive_src();
    end
    chk("blanked_rgb_nonzero_cycles", blank_err, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
